seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/seg_scan_driver_prescaler.sv | 40 ++++
 rtl/seg_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// ----------------------------------------------------------------------------
// seg_scan_pkg
// Shared types and constants for the multiplexed 7-segment scan driver.
//   slot_t            : 2-bit digit slot index (0..3)
//   state_t           : scan controller states (IDLE / RUN)
//   SEG_BLANK_DEFAULT : segment pattern with every segment off (active-low)
//   AN_OFF            : anode pattern with every digit disabled (active-low)
//   slot_to_an()      : slot index -> active-low digit enable pattern
// ----------------------------------------------------------------------------
package seg_scan_pkg;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK_DEFAULT = 7'h7F;
    localparam logic [3:0] AN_OFF            = 4'hF;

    // Slot-to-enable table, slot 0 in the low nibble:
    // slot0=0111, slot1=1011, slot2=1101, slot3=1110
    localparam logic [15:0] AN_TABLE = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [3:0] slot_to_an(input slot_t slot);
        return AN_TABLE[{slot, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_scan_driver_prescaler.sv
// ----------------------------------------------------------------------------
// scan_prescaler
// Digit-slot timebase. Counts 0..TICK_DIV-1 while run is high and wraps;
// holds at 0 whenever run is low.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   run   in   count enable; low clears the counter on the next edge
//   cnt   out  current position inside the digit slot
//   wrap  out  high in the last cycle of a slot while running (slot advance)
// ----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign wrap = run && (cnt_reg == CNT_MAX);
    assign cnt  = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!run || wrap) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A snapshot of all four digit patterns is taken at the start of every frame
// so the display never tears mid-frame; each digit is then shown for
// TICK_DIV clocks in turn.
//
// Parameters:
//   TICK_DIV  clk cycles per digit slot (>= 2)
//   BLANK_CYC blanked cycles at the start of each slot (< TICK_DIV)
//   SEG_BLANK all-segments-off pattern (active-low segments)
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   scan enable (level)
//   seg_a..seg_d in   per-digit segment patterns
//   seg_out      out  shared segment bus
//   an_n         out  active-low digit enables, at most one low
//   frame_start  out  one-cycle pulse at slot0/cnt0
// Build option:
//   SEG_SCAN_BLANK_EN  when defined, the first BLANK_CYC cycles of every slot
//                      are blanked (anti-ghosting). Otherwise BLANK_CYC only
//                      takes part in the parameter legality check.
//
// All outputs are decoded purely from registers (state, slot, cnt, snapshot);
// the inputs only feed next-state logic.
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int         TICK_DIV  = 50000,
    parameter int         BLANK_CYC = 16,
    parameter logic [6:0] SEG_BLANK = SEG_BLANK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    input  logic [6:0] seg_c,
    input  logic [6:0] seg_d,
    output logic [6:0] seg_out,
    output logic [3:0] an_n,
    output logic       frame_start
);

    localparam int CNT_W = $clog2(TICK_DIV);

    // Elaboration-time parameter legality check
    if (TICK_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= TICK_DIV) begin : g_bad_params
        $error("seg_scan_driver: need TICK_DIV >= 2 and 0 <= BLANK_CYC < TICK_DIV");
    end

    state_t           state_reg;
    state_t           state_next;
    slot_t            slot_reg;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             run;
    logic             snap_load;
    logic             blank;
    logic [6:0]       seg_in   [4];
    logic [6:0]       snap_arr [4];

    // Counting only continues on edges where en is still high; the edge that
    // sees en=0 clears cnt and slot together with the RUN->IDLE transition.
    assign run = (state_reg == ST_RUN) && en;

    // Snapshot is taken on the edge that lands on slot0/cnt0: either the
    // IDLE->RUN entry or the wrap out of slot 3.
    assign snap_load = ((state_reg == ST_IDLE) && en) ||
                       (wrap && (slot_reg == 2'd3));

    scan_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign seg_in[0] = seg_a;
    assign seg_in[1] = seg_b;
    assign seg_in[2] = seg_c;
    assign seg_in[3] = seg_d;

    // Per-digit snapshot registers
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
        logic [6:0] snap_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                snap_reg <= SEG_BLANK;
            end else if (snap_load) begin
                snap_reg <= seg_in[gi];
            end
        end

        assign snap_arr[gi] = snap_reg;
    end

    // Slot index: advances on each prescaler wrap, held at 0 outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg <= 2'd0;
        end else if (!run) begin
            slot_reg <= 2'd0;
        end else if (wrap) begin
            slot_reg <= slot_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    assign blank = (cnt < BLANK_LIM);
`else
    assign blank = 1'b0;
`endif

    // Next state and output decode (outputs depend on registers only)
    always_comb begin
        state_next  = state_reg;
        seg_out     = SEG_BLANK;
        an_n        = AN_OFF;
        frame_start = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end
                frame_start = (slot_reg == 2'd0) && (cnt == '0);
                if (!blank) begin
                    seg_out = snap_arr[slot_reg];
                    an_n    = slot_to_an(slot_reg);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver
// Scoreboard bench for seg_scan_driver with TICK_DIV=8, BLANK_CYC=2.
// The stimulus process tracks the frame position (0..31) and pushes the
// expected {an_n, seg_out, frame_start} for every cycle into a queue; a
// monitor on the falling edge pops and compares. A few directed checks with
// hand-written constants are made at the interesting points of the scan.
// Works with or without SEG_SCAN_BLANK_EN defined.
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int TICK_DIV  = 8;
    localparam int BLANK_CYC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [6:0] seg_a, seg_b, seg_c, seg_d;
    logic [6:0] seg_out;
    logic [3:0] an_n;
    logic       frame_start;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;

    exp_t exp_q[$];

    // Reference position tracker
    logic       m_run;
    int         m_pos;
    logic [6:0] m_snap [4];

    seg_scan_driver #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .SEG_BLANK (7'h7F)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seg_a       (seg_a),
        .seg_b       (seg_b),
        .seg_c       (seg_c),
        .seg_d       (seg_d),
        .seg_out     (seg_out),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model_exp();
        exp_t e;
        int   slot;
        int   cnt;
        logic blank;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fs  = 1'b0;
        if (m_run) begin
            slot = m_pos / TICK_DIV;
            cnt  = m_pos % TICK_DIV;
`ifdef SEG_SCAN_BLANK_EN
            blank = (cnt < BLANK_CYC);
`else
            blank = 1'b0;
`endif
            e.fs = (m_pos == 0);
            if (!blank) begin
                e.seg = m_snap[slot];
                case (slot)
                    0:       e.an = 4'b0111;
                    1:       e.an = 4'b1011;
                    2:       e.an = 4'b1101;
                    default: e.an = 4'b1110;
                endcase
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
    endtask

    // One clock: sample inputs as the DUT will see them, advance the model,
    // push the expectation for the new cycle.
    task automatic tick();
        logic       en_s;
        logic       rst_s;
        logic [6:0] in_s [4];
        en_s    = en;
        rst_s   = rst_n;
        in_s[0] = seg_a;
        in_s[1] = seg_b;
        in_s[2] = seg_c;
        in_s[3] = seg_d;
        @(posedge clk);
        if (!rst_s) begin
            model_reset();
        end else if (!m_run) begin
            if (en_s) begin
                m_run  = 1'b1;
                m_pos  = 0;
                m_snap = in_s;
            end
        end else if (!en_s) begin
            m_run = 1'b0;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % (4 * TICK_DIV);
            if (m_pos == 0) m_snap = in_s;
        end
        exp_q.push_back(model_exp());
        #1;
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        vec_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Monitor: compare every cycle that has a queued expectation
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{an: an_n, seg: seg_out, fs: frame_start};
            vec_cnt++;
            if (act !== e) begin
                fail_cnt++;
                $display("FAIL scoreboard cyc %0d: got an_n=%b seg_out=%h fs=%b, want an_n=%b seg_out=%h fs=%b",
                         cyc, act.an, act.seg, act.fs, e.an, e.seg, e.fs);
            end else begin
                $display("cyc %0d: an_n=%b seg_out=%h fs=%b", cyc, act.an, act.seg, act.fs);
            end
        end
    end

    initial begin
        exp_t e;
        model_reset();
        rst_n = 1'b1;
        en    = 1'b0;
        seg_a = 7'h40;
        seg_b = 7'h79;
        seg_c = 7'h24;
        seg_d = 7'h30;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 chk("reset_no_clk", {an_n, seg_out, frame_start}, {4'hF, 7'h7F, 1'b0});

        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_an", {8'h00, an_n}, {8'h00, 4'hF});

        // Frame 0: enter RUN
        en = 1'b1;
        tick();
        chk("entry_fs", {11'h000, frame_start}, 12'h001);
`ifdef SEG_SCAN_BLANK_EN
        chk("slot0_cnt0", {1'b0, an_n, seg_out}, {1'b0, 4'hF, 7'h7F});
`else
        chk("slot0_cnt0", {1'b0, an_n, seg_out}, {1'b0, 4'b0111, 7'h40});
`endif
        repeat (2) tick();
        chk("slot0_cnt2", {1'b0, an_n, seg_out}, {1'b0, 4'b0111, 7'h40});
        tick();
        seg_b = 7'h12;                      // changed mid-frame
        repeat (7) tick();                  // slot1/cnt2
        chk("slot1_old_b", {1'b0, an_n, seg_out}, {1'b0, 4'b1011, 7'h79});
        repeat (22) tick();                 // frame 1 start
        chk("frame1_fs", {11'h000, frame_start}, 12'h001);
        repeat (10) tick();                 // slot1/cnt2
        chk("slot1_new_b", {1'b0, an_n, seg_out}, {1'b0, 4'b1011, 7'h12});
        repeat (11) tick();                 // slot2/cnt5

        // Drop enable
        en = 1'b0;
        tick();
        chk("en_drop_an", {1'b0, an_n, seg_out}, {1'b0, 4'hF, 7'h7F});
        repeat (3) tick();
        en = 1'b1;
        tick();
        chk("reassert_fs", {11'h000, frame_start}, 12'h001);
        repeat (28) tick();                 // slot3/cnt4
        chk("slot3_cnt4", {1'b0, an_n, seg_out}, {1'b0, 4'b1110, 7'h30});

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_run", {an_n, seg_out, frame_start}, {4'hF, 7'h7F, 1'b0});
        model_reset();
        e = exp_q.pop_back();
        exp_q.push_back(model_exp());
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_fs", {11'h000, frame_start}, 12'h001);
        repeat (10) tick();
        chk("restart_slot1", {1'b0, an_n, seg_out}, {1'b0, 4'b1011, 7'h12});

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 12'(exp_q.size()), 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
